// File: rtl/csc_pkg.sv
// Shared types and defaults for the CPU-to-UART TX byte buffer.
package csc_pkg;

  localparam int unsigned DEF_DEPTH_LOG2   = 4;
  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: memory, wrapping pointers and a separate occupancy count.
module sync_fifo
  import csc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head_c,
  output logic                  o_drop_c,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign pop_ok   = i_pop && !o_empty;
  assign push_ok  = i_push && (!o_full || pop_ok);
  assign o_drop_c = i_push && !push_ok;
  assign o_head_c = mem[rd_q];

  always_comb begin
    count_nxt = o_count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_q] <= i_push_data;
    end
  end

  // Flags are registered alongside the count so they never glitch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      o_count <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      o_count <= count_nxt;
      o_empty <= (count_nxt == CW'(0));
      o_full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/csc_tx_fifo.sv
// Buffers bytes from CPU TX falling edges and feeds them to the UART
// transmitter through a one-cycle strobe / busy handshake.
module csc_tx_fifo
  import csc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tx,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_busy,
  output logic                  o_stb,
  output logic [WIDTH-1:0]      o_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow
);

  localparam int unsigned TW = cnt_width(BUSY_TIMEOUT);

  tx_state_e        state_q;
  logic [TW-1:0]    timer_q;
  logic             old_tx_q;
  logic             push_req_c;
  logic             pop_c;
  logic             drop_c;
  logic [WIDTH-1:0] head_c;

  assign push_req_c = !i_tx && old_tx_q;
  assign pop_c      = (state_q == IDLE) && !o_empty && !i_busy;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push_req_c),
    .i_push_data (i_data),
    .i_pop       (pop_c),
    .o_head_c    (head_c),
    .o_drop_c    (drop_c),
    .o_count     (o_count),
    .o_empty     (o_empty),
    .o_full      (o_full)
  );

  // Falling-edge detector and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      old_tx_q   <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      old_tx_q   <= i_tx;
      o_overflow <= o_overflow | drop_c;
    end
  end

  // Pop FSM; o_stb is high exactly while the state is STROBE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      o_stb   <= 1'b0;
      o_data  <= '0;
    end else begin
      o_stb <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop_c) begin
            o_data  <= head_c;
            o_stb   <= 1'b1;
            state_q <= STROBE;
          end
        end
        STROBE: begin
          timer_q <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never raises busy is assumed to have sent the byte.
          if (i_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!i_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csc_tx_fifo.sv
// Randomized bench for csc_tx_fifo with a queue-based byte scoreboard.
module tb_csc_tx_fifo;

  localparam int unsigned DL    = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned BT    = 4;
  localparam int unsigned DEPTH = 1 << DL;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_tx = 1'b1;
  logic [W-1:0]  i_data = '0;
  logic          i_busy = 1'b0;
  logic          o_stb;
  logic [W-1:0]  o_data;
  logic [DL:0]   o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_overflow;

  csc_tx_fifo #(
    .DEPTH_LOG2   (DL),
    .WIDTH        (W),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tx       (i_tx),
    .i_data     (i_data),
    .i_busy     (i_busy),
    .o_stb      (o_stb),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: bytes waiting, sticky overflow, last TX level.
  logic [W-1:0] mq[$];
  logic [W-1:0] got[$];
  int           stb_cyc[$];
  logic         m_ovf = 1'b0;
  logic         m_old_tx = 1'b1;
  logic [W-1:0] m_last = '0;
  logic         prev_stb = 1'b0;
  int           stb_total = 0;

  // Transmitter model: 0 = busy tied low, 1 = busy forced high, 2 = reacts to strobes.
  int bmode  = 0;
  bit bfixed = 1'b0;
  int bz_wait = 0;
  int bz_hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_bmode(input int m, input bit fixed);
    bmode   = m;
    bfixed  = fixed;
    bz_wait = 0;
    bz_hold = 0;
  endtask

  task automatic step();
    logic         tx_s;
    logic         busy_s;
    logic         rst_s;
    logic [W-1:0] d_s;
    bit           push_req;
    tx_s   = i_tx;
    busy_s = i_busy;
    rst_s  = i_reset;
    d_s    = i_data;
    @(posedge i_clk);
    #1;
    cyc++;
    if (rst_s) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_old_tx = 1'b1;
      m_last   = '0;
      check("rst_stb", 32'(o_stb), 32'(0));
      check("rst_data", 32'(o_data), 32'(0));
    end else begin
      if (o_stb) begin
        check("stb_back_to_back", 32'(prev_stb), 32'(0));
        check("stb_while_busy", 32'(busy_s), 32'(0));
        check("stb_nonempty", 32'(mq.size() != 0), 32'(1));
        if (mq.size() != 0) begin
          check("pop_data", 32'(o_data), 32'(mq[0]));
          m_last = mq.pop_front();
        end
        stb_total++;
        got.push_back(o_data);
        stb_cyc.push_back(cyc);
      end else begin
        check("data_hold", 32'(o_data), 32'(m_last));
      end
      push_req = !tx_s && m_old_tx;
      if (push_req) begin
        if (mq.size() < DEPTH) mq.push_back(d_s);
        else m_ovf = 1'b1;
      end
      m_old_tx = tx_s;
    end
    check("count", 32'(o_count), 32'(mq.size()));
    check("empty", 32'(o_empty), 32'(mq.size() == 0));
    check("full", 32'(o_full), 32'(mq.size() == DEPTH));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    prev_stb = o_stb;
    case (bmode)
      0: i_busy = 1'b0;
      1: i_busy = 1'b1;
      default: begin
        if (o_stb) begin
          bz_wait = bfixed ? 0 : int'($urandom_range(6, 0));
          bz_hold = bfixed ? 100 : int'($urandom_range(30, 1));
        end
        i_busy = (bz_wait == 0) && (bz_hold > 0);
        if (bz_wait > 0) bz_wait--;
        else if (bz_hold > 0) bz_hold--;
      end
    endcase
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_tx    = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  task automatic edge_push(input logic [W-1:0] d);
    i_tx   = 1'b0;
    i_data = d;
    step();
    i_tx   = 1'b1;
    step();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    i_tx = 1'b1;
    while ((mq.size() != 0 || o_count != 0) && n < bound) begin
      step();
      n++;
    end
    check("drain_bound", 32'(n < bound), 32'(1));
  endtask

  task automatic random_run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      i_tx   = ($urandom_range(1, 0) != 0);
      i_data = W'($urandom);
      step();
    end
  endtask

  initial begin
    int s0;
    int t0;
    int n;

    // Single byte with an idle transmitter: strobe two cycles after the edge.
    set_bmode(0, 1'b0);
    do_reset();
    repeat (8) step();
    s0 = stb_total;
    i_tx = 1'b0;
    i_data = 8'hA5;
    step();
    check("t1_no_stb_at_push", 32'(o_stb), 32'(0));
    check("t1_count_after_push", 32'(o_count), 32'(1));
    step();
    check("t1_stb", 32'(o_stb), 32'(1));
    check("t1_data", 32'(o_data), 32'(8'hA5));
    i_tx = 1'b1;
    repeat (30) step();
    check("t1_one_stb", 32'(stb_total - s0), 32'(1));
    check("t1_count_zero", 32'(o_count), 32'(0));

    // TX held low for a long time is a single push.
    s0 = stb_total;
    i_tx = 1'b0;
    i_data = 8'h3C;
    repeat (5000) step();
    i_tx = 1'b1;
    repeat (10) step();
    check("t2_one_stb", 32'(stb_total - s0), 32'(1));
    check("t2_data", 32'(got[got.size() - 1]), 32'(8'h3C));

    // Burst of 17 edges into a stalled transmitter: last byte dropped.
    set_bmode(1, 1'b0);
    do_reset();
    for (int i = 0; i < 17; i++) edge_push(W'(i));
    check("t3_full", 32'(o_full), 32'(1));
    check("t3_count16", 32'(o_count), 32'(16));
    check("t3_overflow", 32'(o_overflow), 32'(1));
    got.delete();
    set_bmode(2, 1'b1);
    i_busy = 1'b0;
    drain(5000);
    repeat (5) step();
    check("t3_nbytes", 32'(got.size()), 32'(16));
    for (int i = 0; i < 16 && i < got.size(); i++) check("t3_order", 32'(got[i]), 32'(i));
    check("t3_overflow_sticky", 32'(o_overflow), 32'(1));

    // Full FIFO with a pop on the same edge as a new push.
    set_bmode(1, 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) edge_push(W'($urandom));
    check("t4_full_before", 32'(o_full), 32'(1));
    got.delete();
    set_bmode(2, 1'b1);
    i_busy = 1'b0;
    i_tx = 1'b0;
    i_data = 8'h77;
    step();
    check("t4_stb", 32'(o_stb), 32'(1));
    check("t4_count16", 32'(o_count), 32'(16));
    check("t4_no_overflow", 32'(o_overflow), 32'(0));
    drain(5000);
    repeat (5) step();
    check("t4_nbytes", 32'(got.size()), 32'(17));
    if (got.size() != 0) check("t4_last", 32'(got[got.size() - 1]), 32'(8'h77));

    // Busy never rises: strobes spaced by the timeout plus two cycles.
    set_bmode(0, 1'b0);
    do_reset();
    got.delete();
    stb_cyc.delete();
    i_tx = 1'b0; i_data = 8'h11; step();
    i_tx = 1'b1; step();
    i_tx = 1'b0; i_data = 8'h22; step();
    i_tx = 1'b1;
    repeat (30) step();
    check("t5_nstb", 32'(stb_cyc.size()), 32'(2));
    if (stb_cyc.size() == 2) begin
      check("t5_spacing", 32'(stb_cyc[1] - stb_cyc[0]), 32'(BT + 2));
      check("t5_first", 32'(got[0]), 32'(8'h11));
      check("t5_second", 32'(got[1]), 32'(8'h22));
    end

    // Reset while waiting on the transmitter discards the queue.
    set_bmode(2, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) edge_push(W'(8'hC0 + i));
    repeat (10) step();
    check("t6_queued", 32'(o_count), 32'(3));
    check("t6_busy_high", 32'(i_busy), 32'(1));
    do_reset();
    check("t6_rst_count", 32'(o_count), 32'(0));
    check("t6_rst_empty", 32'(o_empty), 32'(1));
    check("t6_rst_stb", 32'(o_stb), 32'(0));
    got.delete();
    s0 = stb_total;
    t0 = cyc;
    edge_push(8'h5A);
    n = 0;
    while (stb_total == s0 && n < 400) begin
      step();
      n++;
    end
    check("t6_stb_seen", 32'(stb_total - s0), 32'(1));
    if (got.size() != 0) begin
      check("t6_data", 32'(got[0]), 32'(8'h5A));
      check("t6_waited_busy", 32'((stb_cyc[stb_cyc.size() - 1] - t0) > 50), 32'(1));
    end
    drain(5000);

    // Random traffic against a timeout-only transmitter, then a reactive one.
    set_bmode(0, 1'b0);
    do_reset();
    random_run(1500);
    drain(2000);
    set_bmode(2, 1'b0);
    do_reset();
    random_run(3000);
    drain(20000);
    repeat (50) step();
    check("final_empty", 32'(o_empty), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
